// File: rtl/eth_pcs_tx_gearbox.sv
// 10GBASE-R PCS transmit gearbox: packs 2-bit sync header + 64-bit payload blocks,
// delivered as two 32-bit transfers, into a continuous 32-bit PMA word stream.
module eth_pcs_tx_gearbox #(
   parameter int W_DATA = 32,
   parameter int W_SYNC = 2
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   input  logic              i_hdr_valid,
   input  logic [W_SYNC-1:0] i_hdr,
   input  logic [W_DATA-1:0] i_data,
   output logic              o_ready,
   output logic              o_pma_valid,
   output logic [W_DATA-1:0] o_pma_data,
   output logic              o_align_err
);

   localparam int W_COMB = 2 * W_DATA;

   logic [5:0]        cnt;
   logic [5:0]        lvl;
   logic [W_DATA-1:0] res;
   logic              hdr_phase;
   logic              drain;
   logic              accept;
   logic [W_COMB-1:0] new_ext;
   logic [W_COMB-1:0] combined;

   always_comb begin
      hdr_phase = ~cnt[0];
      // Residue fill level is 2*ceil(cnt/2): round odd counts up by one.
      lvl       = cnt + {5'd0, cnt[0]};
      drain     = (cnt == 6'd32);
      o_ready   = ~drain;
      accept    = o_ready & i_valid;
      new_ext   = hdr_phase ? {{(W_COMB-W_DATA-W_SYNC){1'b0}}, i_data, i_hdr}
                            : {{(W_COMB-W_DATA){1'b0}}, i_data};
      // NOTE: res is cleared on drain and its bits above lvl are always zero,
      // so the residue merges with a plain OR and needs no mask.
      combined  = (new_ext << lvl) | {{(W_COMB-W_DATA){1'b0}}, res};
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt         <= '0;
         res         <= '0;
         o_pma_data  <= '0;
         o_pma_valid <= 1'b0;
         o_align_err <= 1'b0;
      end else if (drain) begin
         o_pma_data  <= res;
         o_pma_valid <= 1'b1;
         res         <= '0;
         cnt         <= '0;
         o_align_err <= 1'b0;
      end else if (accept) begin
         o_pma_data  <= combined[W_DATA-1:0];
         res         <= combined[W_COMB-1:W_DATA];
         o_pma_valid <= 1'b1;
         cnt         <= cnt + 6'd1;
         o_align_err <= (i_hdr_valid != hdr_phase);
      end else begin
         o_pma_valid <= 1'b0;
         o_align_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_eth_pcs_tx_gearbox.sv
// Bench for eth_pcs_tx_gearbox: directed vector table, then multi-cycle sequences
// checked against a bit-serial line model.
module tb_eth_pcs_tx_gearbox;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_hdr_valid = 1'b0;
   logic [1:0]  i_hdr = 2'b00;
   logic [31:0] i_data = 32'h0;
   logic        o_ready;
   logic        o_pma_valid;
   logic [31:0] o_pma_data;
   logic        o_align_err;

   eth_pcs_tx_gearbox #(.W_DATA(32), .W_SYNC(2)) dut (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_valid     (i_valid),
      .i_hdr_valid (i_hdr_valid),
      .i_hdr       (i_hdr),
      .i_data      (i_data),
      .o_ready     (o_ready),
      .o_pma_valid (o_pma_valid),
      .o_pma_data  (o_pma_data),
      .o_align_err (o_align_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        valid;
      logic        hv;
      logic [1:0]  hdr;
      logic [31:0] data;
      logic        exp_ready;
      logic        exp_pv;
      logic        chk_data;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t tbl[8];
   int   n_vec = 0;
   int   n_err = 0;
   bit   line_q[$];
   int   m_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus with the line model advanced alongside.
   task automatic step(input bit rst, input bit v, input bit hv, input logic [1:0] hdr,
                       input logic [31:0] data, output bit acc);
      bit          exp_pv;
      bit          exp_err;
      logic [31:0] w;
      @(negedge clk);
      i_reset = rst; i_valid = v; i_hdr_valid = hv; i_hdr = hdr; i_data = data;
      if (!rst) check("ready", {63'd0, o_ready}, {63'd0, (m_cnt != 32)});
      acc     = !rst && v && (m_cnt != 32);
      exp_pv  = !rst && (acc || m_cnt == 32);
      exp_err = acc && (hv != (m_cnt % 2 == 0));
      if (rst) begin
         line_q.delete();
         m_cnt = 0;
      end else if (acc) begin
         if (m_cnt % 2 == 0) begin
            line_q.push_back(hdr[0]);
            line_q.push_back(hdr[1]);
         end
         for (int i = 0; i < 32; i++) line_q.push_back(data[i]);
         m_cnt++;
      end else if (m_cnt == 32) begin
         m_cnt = 0;
      end
      @(posedge clk);
      #1;
      check("pma_valid", {63'd0, o_pma_valid}, {63'd0, exp_pv});
      check("align_err", {63'd0, o_align_err}, {63'd0, exp_err});
      if (rst) check("ready_after_reset", {63'd0, o_ready}, 64'd1);
      if (exp_pv) begin
         if (line_q.size() < 32) begin
            check("model_bits_available", 64'(line_q.size()), 64'd32);
         end else begin
            for (int i = 0; i < 32; i++) w[i] = line_q.pop_front();
            check("pma_data", {32'd0, o_pma_data}, {32'd0, w});
         end
      end
      i_reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit          acc;
      int          lows;
      int          low_at;
      int          words;
      int          idx;
      int          gap;
      logic [63:0] payload;
      logic [31:0] d;
      logic        hv;

      //            rst   v     hv    hdr    data          rdy   pv    chk   exp_data      err
      tbl[0] = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 2'b01, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0003, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 2'b10, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 32'h2345_6788, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 2'b00, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0001, 1'b1};
      tbl[6] = '{1'b0, 1'b1, 1'b1, 2'b11, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0};

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         i_reset = tbl[i].rst; i_valid = tbl[i].valid; i_hdr_valid = tbl[i].hv;
         i_hdr = tbl[i].hdr; i_data = tbl[i].data;
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_ready", i), {63'd0, o_ready}, {63'd0, tbl[i].exp_ready});
         check($sformatf("tbl%0d_pv", i), {63'd0, o_pma_valid}, {63'd0, tbl[i].exp_pv});
         check($sformatf("tbl%0d_err", i), {63'd0, o_align_err}, {63'd0, tbl[i].exp_err});
         if (tbl[i].chk_data)
            check($sformatf("tbl%0d_data", i), {32'd0, o_pma_data}, {32'd0, tbl[i].exp_data});
      end

      // Continuous stream of 16 blocks, then a word offered on the drain cycle.
      step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, acc);
      lows = 0; low_at = -1; words = 0; idx = 0;
      for (int c = 0; c < 34; c++) begin
         if (!o_ready) begin
            lows++;
            low_at = c;
         end
         if (idx < 32) begin
            payload = 64'h0F0E_0D0C_0B0A_0900 + 64'(idx / 2);
            d       = (idx % 2 == 0) ? payload[31:0] : payload[63:32];
            step(1'b0, 1'b1, (idx % 2 == 0), 2'b10, d, acc);
         end else begin
            step(1'b0, 1'b1, 1'b1, 2'b01, 32'hDEAD_BEEF, acc);
         end
         if (acc) idx++;
         if (o_pma_valid && c < 33) words++;
      end
      check("stream_ready_low_count", 64'(lows), 64'd1);
      check("stream_ready_low_cycle", 64'(low_at), 64'd32);
      check("stream_word_count", 64'(words), 64'd33);
      check("stream_transfers_accepted", 64'(idx), 64'd33);

      // Gap of 3 idle cycles at cnt 5 and a misplaced header flag at cnt 9.
      step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, acc);
      gap = 0;
      for (int c = 0; c < 45; c++) begin
         if (m_cnt == 5 && gap < 3) begin
            gap++;
            step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, acc);
         end else begin
            hv = (m_cnt % 2 == 0) ^ (m_cnt == 9);
            step(1'b0, 1'b1, hv, 2'(c), 32'hC0DE_0000 + 32'(c * 32'h0001_0203), acc);
         end
      end

      // Reset in the middle of a sequence at cnt 17.
      step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, acc);
      for (int c = 0; c < 17; c++)
         step(1'b0, 1'b1, (c % 2 == 0), 2'b10, 32'hA5A5_0000 + 32'(c), acc);
      step(1'b1, 1'b1, 1'b0, 2'b11, 32'hFFFF_FFFF, acc);
      step(1'b0, 1'b1, 1'b1, 2'b01, 32'h0000_0000, acc);
      check("post_reset_hdr_bits", {62'd0, o_pma_data[1:0]}, 64'd1);
      check("post_reset_word", {32'd0, o_pma_data}, 64'h0000_0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
